// File: rtl/keypad_lock_ctrl.sv
// rtl/keypad_lock_ctrl.sv - keypad combination-lock controller with password change (optional lockout: LOCKOUT_EN)
module keypad_lock_ctrl #(
   parameter int PWD_LEN = 4,
   parameter logic [4*PWD_LEN-1:0] DEFAULT_PWD = 16'h1234,
   parameter int OPEN_CYCLES = 1000,
   parameter int IDLE_TIMEOUT = 5000,
   parameter int MAX_FAIL = 3,
   parameter int LOCK_CYCLES = 10000
) (
   input  logic                          clk,
   input  logic                          reset_1,
   input  logic [3:0]                    Code_1,
   input  logic                          Valid_1,
   output logic                          OPEN,
   output logic                          LOCK,
   output logic                          SAVE_LIGHT,
   output logic                          SAVE_DONE,
   output logic                          ERR,
   output logic [$clog2(MAX_FAIL+1)-1:0] FAIL_CNT
);
   localparam int W  = 4*PWD_LEN;
   localparam int CW = $clog2(PWD_LEN+1);
   localparam int FW = $clog2(MAX_FAIL+1);
   localparam int OW = $clog2(OPEN_CYCLES+1);
   localparam int IW = $clog2(IDLE_TIMEOUT+1);
   localparam logic [CW-1:0] FULL      = CW'(PWD_LEN);
   localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
   localparam logic [OW-1:0] OPEN_LAST = OW'(OPEN_CYCLES-1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT-1);

   typedef enum logic [2:0] {
      S_IDLE, S_ENTRY, S_OPEN, S_SET_NEW, S_SET_CONFIRM, S_LOCKOUT
   } state_t;

   state_t        state, nxt_state;
   logic [W-1:0]  pwd_buf, nxt_buf;
   logic [CW-1:0] buf_cnt, nxt_cnt;
   logic [W-1:0]  stored_pwd, nxt_stored;
   logic [W-1:0]  new_pwd, nxt_new;
   logic [OW-1:0] open_tmr, nxt_open_tmr;
   logic [IW-1:0] idle_tmr, nxt_idle_tmr;
   logic [FW-1:0] fail_cnt, nxt_fail, fail_inc;
   logic          nxt_done, nxt_err, nxt_open, nxt_light;
   logic          is_digit, is_star, is_hash, is_full, timeout;
   logic [W-1:0]  shifted;
   logic [CW-1:0] cnt_inc;

`ifdef LOCKOUT_EN
   localparam int LW = $clog2(LOCK_CYCLES+1);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES-1);
   logic [LW-1:0] lock_tmr, nxt_lock_tmr;
`else
   logic unused_lock_cfg;
   assign unused_lock_cfg = ^LOCK_CYCLES;
`endif

   // Key decode and entry-buffer helpers shared by all entry-type states
   always_comb begin
      is_digit = Valid_1 && (Code_1 <= 4'd9);
      is_star  = Valid_1 && (Code_1 == 4'hA);
      is_hash  = Valid_1 && (Code_1 == 4'hB);
      shifted  = (pwd_buf << 4) | W'(Code_1);
      cnt_inc  = (buf_cnt == FULL) ? FULL : buf_cnt + CW'(1);
      is_full  = (buf_cnt == FULL);
      fail_inc = (fail_cnt == FAIL_MAX) ? FAIL_MAX : fail_cnt + FW'(1);
      timeout  = ((state == S_ENTRY) || (state == S_SET_NEW) || (state == S_SET_CONFIRM))
                 && !Valid_1 && (idle_tmr == IDLE_LAST);
   end

   // Next-state and next-output logic; every exit to IDLE empties the entry buffer
   always_comb begin
      nxt_state    = state;
      nxt_buf      = pwd_buf;
      nxt_cnt      = buf_cnt;
      nxt_stored   = stored_pwd;
      nxt_new      = new_pwd;
      nxt_open_tmr = open_tmr;
      nxt_idle_tmr = Valid_1 ? '0 : idle_tmr + IW'(1);
      nxt_fail     = fail_cnt;
      nxt_done     = 1'b0;
      nxt_err      = 1'b0;
`ifdef LOCKOUT_EN
      nxt_lock_tmr = lock_tmr;
`endif
      case (state)
         S_IDLE: begin
            if (is_digit) begin
               nxt_buf   = W'(Code_1);
               nxt_cnt   = CW'(1);
               nxt_state = S_ENTRY;
            end
         end
         S_ENTRY, S_SET_NEW, S_SET_CONFIRM: begin
            if (timeout || is_star) begin
               nxt_buf   = '0;
               nxt_cnt   = '0;
               nxt_state = S_IDLE;
            end else if (is_digit) begin
               nxt_buf = shifted;
               nxt_cnt = cnt_inc;
            end else if (is_hash) begin
               nxt_buf   = '0;
               nxt_cnt   = '0;
               nxt_state = S_IDLE;
               if (state == S_ENTRY) begin
                  if (is_full && (pwd_buf == stored_pwd)) begin
                     nxt_state    = S_OPEN;
                     nxt_fail     = '0;
                     nxt_open_tmr = '0;
                  end else begin
                     nxt_err  = 1'b1;
                     nxt_fail = fail_inc;
`ifdef LOCKOUT_EN
                     if (fail_inc == FAIL_MAX) begin
                        nxt_state    = S_LOCKOUT;
                        nxt_lock_tmr = '0;
                     end
`endif
                  end
               end else if (state == S_SET_NEW) begin
                  if (is_full) begin
                     nxt_new   = pwd_buf;
                     nxt_state = S_SET_CONFIRM;
                  end else begin
                     nxt_err = 1'b1;
                  end
               end else begin
                  if (is_full && (pwd_buf == new_pwd)) begin
                     nxt_stored = new_pwd;
                     nxt_done   = 1'b1;
                  end else begin
                     nxt_err = 1'b1;
                  end
               end
            end
         end
         S_OPEN: begin
            if ((open_tmr == OPEN_LAST) || is_hash) begin
               nxt_state = S_IDLE;
            end else if (is_star) begin
               nxt_state = S_SET_NEW;
            end else begin
               nxt_open_tmr = open_tmr + OW'(1);
            end
         end
`ifdef LOCKOUT_EN
         S_LOCKOUT: begin
            if (lock_tmr == LOCK_LAST) begin
               nxt_state = S_IDLE;
               nxt_fail  = '0;
            end else begin
               nxt_lock_tmr = lock_tmr + LW'(1);
            end
         end
`endif
         default: nxt_state = S_IDLE;
      endcase
      nxt_open  = (nxt_state == S_OPEN) || (nxt_state == S_SET_NEW) || (nxt_state == S_SET_CONFIRM);
      nxt_light = (nxt_state == S_SET_NEW) || (nxt_state == S_SET_CONFIRM);
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge reset_1) begin
      if (!reset_1) begin
         state      <= S_IDLE;
         pwd_buf    <= '0;
         buf_cnt    <= '0;
         stored_pwd <= DEFAULT_PWD;
         new_pwd    <= '0;
         open_tmr   <= '0;
         idle_tmr   <= '0;
         fail_cnt   <= '0;
         OPEN       <= 1'b0;
         LOCK       <= 1'b1;
         SAVE_LIGHT <= 1'b0;
         SAVE_DONE  <= 1'b0;
         ERR        <= 1'b0;
         FAIL_CNT   <= '0;
`ifdef LOCKOUT_EN
         lock_tmr   <= '0;
`endif
      end else begin
         state      <= nxt_state;
         pwd_buf    <= nxt_buf;
         buf_cnt    <= nxt_cnt;
         stored_pwd <= nxt_stored;
         new_pwd    <= nxt_new;
         open_tmr   <= nxt_open_tmr;
         idle_tmr   <= nxt_idle_tmr;
         fail_cnt   <= nxt_fail;
         OPEN       <= nxt_open;
         LOCK       <= ~nxt_open;
         SAVE_LIGHT <= nxt_light;
         SAVE_DONE  <= nxt_done;
         ERR        <= nxt_err;
         FAIL_CNT   <= nxt_fail;
`ifdef LOCKOUT_EN
         lock_tmr   <= nxt_lock_tmr;
`endif
      end
   end

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// tb/tb_keypad_lock_ctrl.sv - scoreboard bench for keypad_lock_ctrl
module tb_keypad_lock_ctrl;
   localparam int PWD_LEN = 4;
   localparam int OPEN_CYCLES = 8;
   localparam int IDLE_TIMEOUT = 16;
   localparam int MAX_FAIL = 3;
   localparam int LOCK_CYCLES = 20;

   logic       clk = 1'b0;
   logic       reset_1 = 1'b0;
   logic [3:0] Code_1 = 4'd0;
   logic       Valid_1 = 1'b0;
   logic       OPEN, LOCK, SAVE_LIGHT, SAVE_DONE, ERR;
   logic [1:0] FAIL_CNT;

   int vectors = 0;
   int miscompares = 0;
   logic [6:0] exp_q[$];

   string m_mode;
   int    m_ent[$];
   int    m_stored[$];
   int    m_new[$];
   int    m_fails, m_quiet, m_open_seen, m_lock_seen;
   bit    m_err, m_done;

   keypad_lock_ctrl #(
      .PWD_LEN(PWD_LEN), .DEFAULT_PWD(16'h1234), .OPEN_CYCLES(OPEN_CYCLES),
      .IDLE_TIMEOUT(IDLE_TIMEOUT), .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)
   ) dut (
      .clk(clk), .reset_1(reset_1), .Code_1(Code_1), .Valid_1(Valid_1),
      .OPEN(OPEN), .LOCK(LOCK), .SAVE_LIGHT(SAVE_LIGHT), .SAVE_DONE(SAVE_DONE),
      .ERR(ERR), .FAIL_CNT(FAIL_CNT)
   );

   always #5 clk = ~clk;

   function automatic bit same(int a[$], int b[$]);
      if (a.size() != b.size()) return 1'b0;
      foreach (a[i]) if (a[i] != b[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [6:0] model_out();
      bit op, light;
      op    = (m_mode == "open") || (m_mode == "new") || (m_mode == "confirm");
      light = (m_mode == "new") || (m_mode == "confirm");
      return {op, !op, light, m_done, m_err, 2'(m_fails)};
   endfunction

   task automatic model_reset();
      m_mode = "idle";
      m_ent.delete();
      m_new.delete();
      m_stored = '{1, 2, 3, 4};
      m_fails = 0; m_quiet = 0; m_open_seen = 0; m_lock_seen = 0;
      m_err = 0; m_done = 0;
   endtask

   task automatic model_step(bit v, logic [3:0] c);
      bit dig, star, hash, full;
      dig  = v && (c <= 4'd9);
      star = v && (c == 4'd10);
      hash = v && (c == 4'd11);
      m_err = 0;
      m_done = 0;
      if (m_mode == "idle") begin
         if (dig) begin
            m_ent.delete();
            m_ent.push_back(int'(c));
            m_quiet = 0;
            m_mode = "entry";
         end
      end else if (m_mode == "entry" || m_mode == "new" || m_mode == "confirm") begin
         m_quiet = v ? 0 : m_quiet + 1;
         if (m_quiet == IDLE_TIMEOUT || star) begin
            m_ent.delete();
            m_mode = "idle";
         end else if (dig) begin
            m_ent.push_back(int'(c));
            if (m_ent.size() > PWD_LEN) void'(m_ent.pop_front());
         end else if (hash) begin
            full = (m_ent.size() == PWD_LEN);
            if (m_mode == "entry") begin
               if (full && same(m_ent, m_stored)) begin
                  m_mode = "open";
                  m_fails = 0;
                  m_open_seen = 0;
               end else begin
                  m_err = 1;
                  if (m_fails < MAX_FAIL) m_fails++;
                  m_mode = "idle";
`ifdef LOCKOUT_EN
                  if (m_fails == MAX_FAIL) begin
                     m_mode = "lockout";
                     m_lock_seen = 0;
                  end
`endif
               end
            end else if (m_mode == "new") begin
               if (full) begin
                  m_new = m_ent;
                  m_mode = "confirm";
               end else begin
                  m_err = 1;
                  m_mode = "idle";
               end
            end else begin
               if (full && same(m_ent, m_new)) begin
                  m_stored = m_new;
                  m_done = 1;
               end else begin
                  m_err = 1;
               end
               m_mode = "idle";
            end
            m_ent.delete();
         end
      end else if (m_mode == "open") begin
         m_open_seen++;
         if (m_open_seen == OPEN_CYCLES || hash) m_mode = "idle";
         else if (star) begin
            m_mode = "new";
            m_ent.delete();
            m_quiet = 0;
         end
      end else if (m_mode == "lockout") begin
         m_lock_seen++;
         if (m_lock_seen == LOCK_CYCLES) begin
            m_mode = "idle";
            m_fails = 0;
         end
      end
   endtask

   task automatic cycle(bit v, logic [3:0] c);
      @(negedge clk);
      Valid_1 = v;
      Code_1 = c;
      if (reset_1) model_step(v, c);
      exp_q.push_back(model_out());
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 4'd0);
   endtask

   task automatic type_keys(int keys[$]);
      foreach (keys[i]) cycle(1'b1, 4'(keys[i]));
   endtask

   task automatic type_stored_hash();
      int k[$];
      k = m_stored;
      k.push_back(11);
      type_keys(k);
   endtask

   task automatic do_reset();
      logic [6:0] got;
      @(negedge clk);
      reset_1 = 1'b0;
      Valid_1 = 1'b0;
      model_reset();
      #1;
      got = {OPEN, LOCK, SAVE_LIGHT, SAVE_DONE, ERR, FAIL_CNT};
      vectors++;
      if (got !== model_out()) begin
         miscompares++;
         $display("FAIL async_reset: got %b expected %b", got, model_out());
      end
      exp_q.push_back(model_out());
      idle(2);
      @(negedge clk);
      reset_1 = 1'b1;
      model_step(1'b0, 4'd0);
      exp_q.push_back(model_out());
   endtask

   // Monitor: one expected output vector per rising edge, compared just after it
   initial begin
      logic [6:0] e, got;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {OPEN, LOCK, SAVE_LIGHT, SAVE_DONE, ERR, FAIL_CNT};
            vectors++;
            if (got !== e) begin
               miscompares++;
               $display("FAIL outputs @%0t: got {OPEN,LOCK,LIGHT,DONE,ERR,FCNT}=%b expected %b", $time, got, e);
            end
         end
      end
   end

   initial begin
      model_reset();
      reset_1 = 1'b0;
      idle(2);
      @(negedge clk);
      reset_1 = 1'b1;
      model_step(1'b0, 4'd0);
      exp_q.push_back(model_out());

      type_keys('{1, 2, 3, 4, 11});        idle(10);
      type_keys('{9, 1, 2, 3, 4, 11});     idle(10);
      type_keys('{1, 2, 3, 11});           idle(2);
      type_keys('{1, 2, 3, 4, 11, 10, 5, 6, 7, 8, 11, 5, 6, 7, 8, 11}); idle(2);
      type_keys('{5, 6, 7, 8, 11});        idle(10);
      type_keys('{1, 2, 3, 4, 11});        idle(2);
      do_reset();
      type_keys('{1, 2, 3, 4, 11, 10, 5, 6, 7, 8, 11, 5, 6, 7, 9, 11}); idle(2);
      type_keys('{1, 2, 3, 4, 11});        idle(10);
      type_keys('{1, 2});                  idle(16);
      type_keys('{3, 4, 11});              idle(2);
      type_keys('{12, 1, 15, 2, 3, 4, 11}); idle(10);
      for (int i = 0; i < 4; i++) begin
         type_keys('{7, 7, 7, 7, 11});
         type_keys('{1, 2, 3, 4, 11});
         idle(2);
      end
      idle(30);
      type_keys('{1, 2});
      do_reset();
      type_keys('{1, 2, 3, 4, 11, 10, 5, 6, 7, 8, 11, 5, 6});
      do_reset();
      type_keys('{1, 2, 3, 4, 11});        idle(10);

      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: cycle(1'b1, 4'($urandom_range(0, 15)));
            4, 5:       type_stored_hash();
            6: begin
               type_stored_hash();
               cycle(1'b1, 4'd10);
            end
            7:          idle($urandom_range(0, 20));
            8: type_keys('{$urandom_range(0, 9), $urandom_range(0, 9),
                           $urandom_range(0, 9), $urandom_range(0, 9), 11});
            default:    cycle(1'b1, 4'd10);
         endcase
         if ($urandom_range(0, 99) == 0) do_reset();
      end
      idle(5);

      for (int t = 0; t < 5 && exp_q.size() > 0; t++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected vectors never compared, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
